m_ext_sequencer: RTL and testbench
==================================

Name: m_ext_sequencer

Overview:
- Multi-cycle sequencer for the RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) decoded in EX.
- Captures the EX operands, runs an iterative shift-add multiply or restoring divide, stalls the pipeline while it works, then presents the result to the EX ALU.
- Results appear on result_m, qualified by a one-cycle flagM that selects result_m as ALUResult.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_valid  in  1  EX holds an M-extension instruction; qualified by alu_opE.
- alu_opE  in  5  ALU op code. M codes: MUL=01011, MULH=01100, MULHSU=01101, MULHU=01110, DIV=01111, DIVU=10000, REM=10001, REMU=10010.
- SrcAE  in  XLEN  operand A (rs1).
- SrcBE  in  XLEN  operand B (rs2).
- flush  in  1  EX flush (branch/jump taken); aborts the operation.
- stall_m  out  1  holds IF/ID/EX (pipeline stall request).
- flagM  out  1  result_m valid this cycle.
- result_m  out  XLEN  M-op result.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; stall_m=0, flagM=0, busy=0, result_m=0; counter and internal registers cleared. Reset mid-operation abandons the operation with no result.
- accept = m_valid & (alu_opE in 01011..10010) & state==IDLE & ~flush. Other opcodes are ignored.
- FSM states:
  - IDLE: on accept, latch operands and op, counter=0, go to CALC.
  - CALC: one iteration per cycle. At counter==XLEN-1, go to DONE. flush goes to IDLE.
  - DONE: flagM=1, result_m valid. Next cycle goes to IDLE unconditionally; m_valid is ignored in DONE, so the held instruction is not re-accepted.
- stall_m = accept (combinational, in the IDLE cycle) | state==CALC. It is 0 in DONE, so the pipeline advances with the result that cycle.
- Latency: accepted at cycle T → flagM at T+XLEN+1 (T+33). Exactly one flagM pulse per accepted op.
- Operand capture: signed ops store magnitudes plus sign flags.
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - MUL: treated as unsigned (low word is sign-agnostic).
- Multiply: 2*XLEN-bit product register; add the multiplicand when the multiplier LSB is set, then shift.
  - If the signs differ, two's-complement negate the 64-bit product at DONE.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide: restoring divide, one quotient bit per cycle.
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
- Divide boundary cases (resolved at DONE, full latency kept):
  - Divide by zero: DIV/DIVU return 32'hFFFFFFFF; REM/REMU return the dividend.
  - Signed overflow (A=32'h80000000, B=32'hFFFFFFFF): DIV returns 32'h80000000, REM returns 0.
- result_m holds its value after DONE until the next DONE; flagM is 0 outside DONE.
- flush:
  - In the accept cycle: suppresses accept.
  - In CALC: returns to IDLE next cycle, stall_m drops, no flagM.
  - In DONE: no effect.
- Operand inputs are sampled only at accept; later changes are ignored.

Optional Feature:
- Macro: M_SEQ_EARLY_OUT_EN.
- Defined: these cases skip CALC and go IDLE→DONE, so flagM arrives at T+1 and stall_m is high only in the accept cycle:
  - divide by zero;
  - signed overflow;
  - any multiply with operand A or B equal to 0 (result 0).
- Undefined: every op takes the full XLEN+1 cycles.

Test Plan:
- MUL A=7, B=-3 (32'hFFFFFFFD) → stall_m high 33 cycles, flagM at T+33, result_m=32'hFFFFFFEB.
- MULH A=32'h80000000, B=32'h80000000 → 32'h40000000. MULHSU A=-1, B=32'hFFFFFFFF → 32'hFFFFFFFF. MULHU same operands → 32'hFFFFFFFE.
- DIV A=-7, B=2 → 32'hFFFFFFFD; REM same operands → 32'hFFFFFFFF. DIVU A=100, B=7 → 14; REMU same operands → 2.
- DIV A=5, B=0 → 32'hFFFFFFFF; REM same operands → 5. DIV A=32'h80000000, B=-1 → 32'h80000000; REM same operands → 0. With M_SEQ_EARLY_OUT_EN these complete at T+1.
- Start DIVU, then assert flush at T+10 → IDLE at T+11, stall_m=0, no flagM. Back-to-back MUL issued the cycle after DONE is accepted and yields a correct result.
- Start MUL, pull rst_n low at T+5 → all outputs 0 immediately. After release, a fresh MUL 3×4 → 12 at T'+33. With m_valid held through DONE, exactly one flagM pulse is produced.

Source files
------------

// File: rtl/m_ext_sequencer.sv
// ---------------------------------------------------------------------------
// m_ext_sequencer
//
// Multi-cycle sequencer for the RV32M instructions decoded in EX. It captures
// the EX operands, runs an iterative shift-add multiply or a restoring divide
// (one bit per cycle), stalls IF/ID/EX while it works, then presents the
// result for one cycle on result_m qualified by flagM.
//
// Ports:
//   clk       in   rising-edge system clock
//   rst_n     in   asynchronous active-low reset
//   m_valid   in   EX holds an M-extension instruction (qualified by alu_opE)
//   alu_opE   in   5-bit ALU op code (MUL..REMU = 01011..10010)
//   SrcAE     in   operand A (rs1)
//   SrcBE     in   operand B (rs2)
//   flush     in   EX flush; suppresses accept and aborts a running op
//   stall_m   out  pipeline stall request (accept cycle and CALC)
//   flagM     out  result_m valid this cycle (one pulse per completed op)
//   result_m  out  M-op result, held until the next completion
//   busy      out  sequencer not idle
//
// Optional build macro: M_SEQ_EARLY_OUT_EN
//   When defined, divide by zero, signed divide overflow and multiplies with
//   a zero operand skip CALC and complete the cycle after accept.
// ---------------------------------------------------------------------------
module m_ext_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m_valid,
  input  logic [4:0]      alu_opE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            flush,
  output logic            stall_m,
  output logic            flagM,
  output logic [XLEN-1:0] result_m,
  output logic            busy
);

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [4:0]        r_op;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic              r_signA;
  logic              r_signB;
  logic              r_divZero;
  logic [XLEN-1:0]   r_result;
  logic              r_flagM;

  // Input-side decode used only in the accept cycle
  logic              w_isMop;
  logic              w_accept;
  logic              w_aSigned;
  logic              w_bSigned;
  logic              w_negA;
  logic              w_negB;
  logic [XLEN-1:0]   w_magA;
  logic [XLEN-1:0]   w_magB;
  logic              w_bZero;
  logic              w_earlyHit;
  logic [XLEN-1:0]   w_earlyResult;

  // Datapath step and final result
  logic              w_opIsDiv;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [XLEN-1:0]   w_hiNext;
  logic [XLEN-1:0]   w_loNext;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prodS;
  logic [XLEN-1:0]   w_final;

  assign w_isMop  = (alu_opE >= OP_MUL) && (alu_opE <= OP_REMU);
  assign w_accept = m_valid & w_isMop & (r_state == S_IDLE) & ~flush;

  // Signed operands are stored as magnitude plus sign flag; MUL is sign-agnostic
  assign w_aSigned = (alu_opE == OP_MULH) || (alu_opE == OP_MULHSU) ||
                     (alu_opE == OP_DIV)  || (alu_opE == OP_REM);
  assign w_bSigned = (alu_opE == OP_MULH) || (alu_opE == OP_DIV) ||
                     (alu_opE == OP_REM);
  assign w_negA    = w_aSigned & SrcAE[XLEN-1];
  assign w_negB    = w_bSigned & SrcBE[XLEN-1];
  assign w_magA    = w_negA ? (-SrcAE) : SrcAE;
  assign w_magB    = w_negB ? (-SrcBE) : SrcBE;
  assign w_bZero   = (SrcBE == '0);

`ifdef M_SEQ_EARLY_OUT_EN
  logic w_inIsDiv;
  logic w_ovf;
  logic w_mulZero;

  assign w_inIsDiv = (alu_opE >= OP_DIV);
  assign w_ovf     = ((alu_opE == OP_DIV) || (alu_opE == OP_REM)) &&
                     (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);
  assign w_mulZero = ~w_inIsDiv & ((SrcAE == '0) | w_bZero);
  assign w_earlyHit = (w_inIsDiv & w_bZero) | w_ovf | w_mulZero;

  // Results of the short-circuited cases, taken straight from the inputs
  always_comb begin
    w_earlyResult = '0;
    if (w_inIsDiv && w_bZero) begin
      if ((alu_opE == OP_DIV) || (alu_opE == OP_DIVU))
        w_earlyResult = '1;
      else
        w_earlyResult = SrcAE;
    end else if (w_ovf) begin
      if (alu_opE == OP_DIV)
        w_earlyResult = {1'b1, {(XLEN-1){1'b0}}};
      else
        w_earlyResult = '0;
    end
  end
`else
  assign w_earlyHit    = 1'b0;
  assign w_earlyResult = '0;
`endif

  assign w_opIsDiv = (r_op >= OP_DIV);

  // Multiply: {r_hi,r_lo} holds partial product over the remaining multiplier
  // bits. Divide: r_hi is the partial remainder, r_lo shifts the dividend out
  // at the top while quotient bits enter at the bottom.
  assign w_sum  = {1'b0, r_hi} + {1'b0, r_b};
  assign w_rem  = {r_hi, r_lo[XLEN-1]};
  assign w_ge   = (w_rem >= {1'b0, r_b});
  assign w_diff = w_rem[XLEN-1:0] - r_b;

  // One iteration of the active algorithm
  always_comb begin
    w_hiNext = r_hi;
    w_loNext = r_lo;
    if (w_opIsDiv) begin
      if (w_ge) begin
        w_hiNext = w_diff;
        w_loNext = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hiNext = w_rem[XLEN-1:0];
        w_loNext = {r_lo[XLEN-2:0], 1'b0};
      end
    end else if (r_lo[0]) begin
      {w_hiNext, w_loNext} = {w_sum, r_lo[XLEN-1:1]};
    end else begin
      {w_hiNext, w_loNext} = {1'b0, r_hi, r_lo[XLEN-1:1]};
    end
  end

  assign w_prod  = {w_hiNext, w_loNext};
  assign w_prodS = (r_signA ^ r_signB) ? (-w_prod) : w_prod;

  // Sign fix-up and word selection applied to the last iteration's output.
  // Divide by zero on DIV must not be sign-corrected, so it is forced here.
  always_comb begin
    w_final = '0;
    case (r_op)
      OP_MUL:    w_final = w_prodS[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  w_final = w_prodS[2*XLEN-1:XLEN];
      OP_DIV:    w_final = r_divZero ? '1 :
                           ((r_signA ^ r_signB) ? (-w_loNext) : w_loNext);
      OP_DIVU:   w_final = r_divZero ? '1 : w_loNext;
      OP_REM:    w_final = r_signA ? (-w_hiNext) : w_hiNext;
      OP_REMU:   w_final = w_hiNext;
      default:   w_final = '0;
    endcase
  end

  // Sequencer FSM: IDLE -> CALC (XLEN iterations) -> DONE -> IDLE.
  // flagM is set on entry to DONE and cleared every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_divZero <= 1'b0;
      r_result  <= '0;
      r_flagM   <= 1'b0;
    end else begin
      r_flagM <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= alu_opE;
            r_hi      <= '0;
            r_lo      <= w_magA;
            r_b       <= w_magB;
            r_signA   <= w_negA;
            r_signB   <= w_negB;
            r_divZero <= w_bZero;
            r_cnt     <= '0;
            if (w_earlyHit) begin
              r_result <= w_earlyResult;
              r_flagM  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_hi  <= w_hiNext;
            r_lo  <= w_loNext;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
              r_result <= w_final;
              r_flagM  <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall_m  = w_accept | (r_state == S_CALC);
  assign flagM    = r_flagM;
  assign result_m = r_result;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_m_ext_sequencer.sv
// ---------------------------------------------------------------------------
// tb_m_ext_sequencer
//
// Directed self-checking bench for m_ext_sequencer. Each operation is issued
// for one cycle (or held through completion), then latency, stall length and
// the result are compared with hand-computed values. Covers signed/unsigned
// multiply and divide, divide by zero, signed overflow, flush, back-to-back
// issue and asynchronous reset mid-operation.
// Honours M_SEQ_EARLY_OUT_EN for the expected latency of the short cases.
// ---------------------------------------------------------------------------
module tb_m_ext_sequencer;

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  logic        clk;
  logic        rst_n;
  logic        m_valid;
  logic [4:0]  alu_opE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        flush;
  logic        stall_m;
  logic        flagM;
  logic [31:0] result_m;
  logic        busy;

  int checks;
  int errors;

  m_ext_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_valid  (m_valid),
    .alu_opE  (alu_opE),
    .SrcAE    (SrcAE),
    .SrcBE    (SrcBE),
    .flush    (flush),
    .stall_m  (stall_m),
    .flagM    (flagM),
    .result_m (result_m),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op in a single cycle (or hold m_valid through DONE when hold=1),
  // then measure latency and stall length and check the result.
  task automatic applyStimulus(input string tag, input logic [4:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input bit early,
                               input bit hold);
    int lat;
    int stallCnt;
    int expLat;
    lat = 0;
`ifdef M_SEQ_EARLY_OUT_EN
    expLat = early ? 1 : 33;
`else
    expLat = 33;
`endif
    @(posedge clk); #1;
    m_valid = 1'b1; alu_opE = op; SrcAE = a; SrcBE = b;
    @(negedge clk);
    checkOutput({tag, " stall_at_accept"}, {31'b0, stall_m}, 32'd1);
    stallCnt = 1;
    @(posedge clk); #1;
    if (!hold) m_valid = 1'b0;
    SrcAE = $urandom;
    SrcBE = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (flagM) begin
        lat = k;
        break;
      end
      if (stall_m) stallCnt++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " stall_cycles"}, 32'(stallCnt), 32'(expLat));
    checkOutput({tag, " result"}, result_m, expRes);
    checkOutput({tag, " stall_in_done"}, {31'b0, stall_m}, 32'd0);
    if (hold) begin
      @(posedge clk); #1;
      m_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checkOutput({tag, " no_second_flag"}, {31'b0, flagM}, 32'd0);
        checkOutput({tag, " idle_after_done"}, {31'b0, busy}, 32'd0);
      end
      checkOutput({tag, " result_held"}, result_m, expRes);
    end
  endtask

  initial begin
    int pulses;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    m_valid = 1'b0;
    alu_opE = 5'd0;
    SrcAE   = 32'd0;
    SrcBE   = 32'd0;
    flush   = 1'b0;

    // Reset state
    #12;
    checkOutput("reset stall_m", {31'b0, stall_m}, 32'd0);
    checkOutput("reset flagM", {31'b0, flagM}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset result_m", result_m, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Non-M opcode is ignored
    @(posedge clk); #1;
    m_valid = 1'b1; alu_opE = 5'b00010; SrcAE = 32'd3; SrcBE = 32'd4;
    @(negedge clk);
    checkOutput("nonM stall_m", {31'b0, stall_m}, 32'd0);
    @(posedge clk); #1;
    m_valid = 1'b0;
    @(negedge clk);
    checkOutput("nonM busy", {31'b0, busy}, 32'd0);

    // Flush in the accept cycle suppresses accept
    @(posedge clk); #1;
    m_valid = 1'b1; alu_opE = OP_MUL; flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_accept stall_m", {31'b0, stall_m}, 32'd0);
    @(posedge clk); #1;
    m_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_accept busy", {31'b0, busy}, 32'd0);

    // Main function
    applyStimulus("MUL_7x-3",     OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0);
    applyStimulus("MULH_min2",    OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0);
    applyStimulus("MULHSU_m1",    OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    applyStimulus("MULHU_max",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
    applyStimulus("DIV_-7/2",     OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0);
    applyStimulus("REM_-7/2",     OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0);
    applyStimulus("DIVU_100/7",   OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b0, 1'b0);
    applyStimulus("REMU_100/7",   OP_REMU,   32'd100,      32'd7,        32'd2,        1'b0, 1'b0);

    // Boundary cases
    applyStimulus("DIV_5/0",      OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
    applyStimulus("REM_5/0",      OP_REM,    32'd5,        32'd0,        32'd5,        1'b1, 1'b0);
    applyStimulus("DIVU_-7/0",    OP_DIVU,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
    applyStimulus("DIV_ovf",      OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0);
    applyStimulus("REM_ovf",      OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0);
    applyStimulus("MUL_0x123",    OP_MUL,    32'd0,        32'd123,      32'd0,        1'b1, 1'b0);

    // Flush during CALC at T+10
    @(posedge clk); #1;
    m_valid = 1'b1; alu_opE = OP_DIVU; SrcAE = 32'd100; SrcBE = 32'd7;
    @(negedge clk);
    @(posedge clk); #1;
    m_valid = 1'b0;
    for (int i = 0; i < 9; i++) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_calc stall_before", {31'b0, stall_m}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_calc stall_after", {31'b0, stall_m}, 32'd0);
    checkOutput("flush_calc busy_after", {31'b0, busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (flagM) pulses++;
    end
    checkOutput("flush_calc no_flagM", 32'(pulses), 32'd0);

    // Back-to-back issue in the cycle after DONE
    applyStimulus("MUL_5x6",      OP_MUL,    32'd5,        32'd6,        32'd30,       1'b0, 1'b0);
    applyStimulus("MUL_b2b",      OP_MUL,    32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 1'b0);

    // Asynchronous reset mid-operation at T+5
    @(posedge clk); #1;
    m_valid = 1'b1; alu_opE = OP_MUL; SrcAE = 32'd9; SrcBE = 32'd9;
    @(negedge clk);
    @(posedge clk); #1;
    m_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset stall_m", {31'b0, stall_m}, 32'd0);
    checkOutput("midreset flagM", {31'b0, flagM}, 32'd0);
    checkOutput("midreset busy", {31'b0, busy}, 32'd0);
    checkOutput("midreset result_m", result_m, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh op after reset, m_valid held through DONE
    applyStimulus("MUL_3x4_hold", OP_MUL,    32'd3,        32'd4,        32'd12,       1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
